paddle_control: RTL and testbench

- Owns the paddle's geometry: horizontal position, fixed vertical position and length.
- Consumes rotary-encoder events from Rotation_direction and length-change requests from state_control.
- Publishes frame-stable paddle_x, paddle_y and length to the paddle drawing stage and to the collision logic in state_control.
- Motion accumulates between frames and commits only on frame_tick, so the drawing stage never sees the paddle move mid-frame.

---
 rtl/paddle_control.sv | 140 ++++++++++++++
 tb/tb_paddle_control.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_control.sv
// Paddle geometry owner: accumulates rotary motion between frames and commits
// position and length on frame_tick; length changes ramp 2 px per frame, centred.
module paddle_control #(
  parameter int SCREEN_W = 640,
  parameter int PADDLE_Y = 440,
  parameter int LEN_MIN  = 32,
  parameter int LEN_DEF  = 64,
  parameter int LEN_MAX  = 128
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic       rotary_event,
  input  logic       rotary_right,
  input  logic [3:0] speed,
  input  logic       len_req_valid,
  input  logic [7:0] len_req,
  output logic       len_req_ready,
  output logic [9:0] paddle_x,
  output logic [9:0] paddle_y,
  output logic [7:0] length,
  output logic       at_left,
  output logic       at_right
);

  typedef enum logic {IDLE, RESIZE} state_t;

  localparam logic [9:0]         X_RST = 10'((SCREEN_W - LEN_DEF) / 2);
  localparam logic [7:0]         L_MIN = 8'(LEN_MIN);
  localparam logic [7:0]         L_MAX = 8'(LEN_MAX);
  localparam logic [7:0]         L_DEF = 8'(LEN_DEF);
  localparam logic signed [11:0] W12   = 12'(SCREEN_W);

  state_t             state;
  logic signed [10:0] pend;
  logic [7:0]         target;

  logic [5:0]         step;
  logic signed [5:0]  delta;
  logic signed [11:0] pend_sum;
  logic signed [10:0] pend_acc;
  logic signed [10:0] pend_eff;
  logic [7:0]         new_len;
  logic signed [11:0] adj;
  logic signed [11:0] raw;
  logic signed [11:0] max_x;
  logic [9:0]         new_x;
  logic [7:0]         req_t;

  always_comb begin
    step  = (speed == 4'd0) ? 6'd1 : {2'b00, speed};
    delta = '0;
    if (enable && rotary_event)
      delta = rotary_right ? $signed(step) : -$signed(step);

    pend_sum = {pend[10], pend} + {{6{delta[5]}}, delta};
    if (pend_sum > 12'sd511)
      pend_acc = 11'sd511;
    else if (pend_sum < -12'sd511)
      pend_acc = -11'sd511;
    else
      pend_acc = pend_sum[10:0];
  end

  // Commit path: one length step, half-step centring adjust, then wall clamp.
  always_comb begin
    pend_eff = enable ? pend : '0;
    new_len  = length;
    adj      = '0;
    if (state == RESIZE) begin
      if (target > length) begin
        new_len = length + 8'd2;
        adj     = -12'sd1;
      end else if (target < length) begin
        new_len = length - 8'd2;
        adj     = 12'sd1;
      end
    end
    raw   = $signed({2'b00, paddle_x}) + {pend_eff[10], pend_eff} + adj;
    max_x = W12 - $signed({4'b0000, new_len});
    if (raw[11])
      new_x = '0;
    else if (raw > max_x)
      new_x = max_x[9:0];
    else
      new_x = raw[9:0];
  end

  always_comb begin
    req_t = len_req;
    if (len_req < L_MIN)
      req_t = L_MIN;
    else if (len_req > L_MAX)
      req_t = L_MAX;
    req_t[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pend     <= '0;
      target   <= L_DEF;
      paddle_x <= X_RST;
      length   <= L_DEF;
      at_left  <= 1'b0;
      at_right <= 1'b0;
    end else begin
      if (frame_tick) begin
        paddle_x <= new_x;
        length   <= new_len;
        at_left  <= (new_x == '0);
        at_right <= (({1'b0, new_x} + {3'b000, new_len}) == 11'(SCREEN_W));
        // A detent coinciding with the tick seeds the next frame's motion.
        pend     <= {{5{delta[5]}}, delta};
      end else begin
        pend <= enable ? pend_acc : '0;
      end

      case (state)
        IDLE: begin
          if (len_req_valid) begin
            target <= req_t;
            if (req_t != length)
              state <= RESIZE;
          end
        end
        RESIZE: begin
          if (frame_tick && new_len == target)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign len_req_ready = (state == IDLE);
  assign paddle_y      = 10'(PADDLE_Y);

endmodule

// File: tb/tb_paddle_control.sv
// Bench for paddle_control: constant vector table, directed corner sequences,
// and randomized traffic checked against a frame-level behavioural model.
module tb_paddle_control;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       frame_tick = 1'b0;
  logic       rotary_event = 1'b0;
  logic       rotary_right = 1'b0;
  logic [3:0] speed = 4'd0;
  logic       len_req_valid = 1'b0;
  logic [7:0] len_req = 8'd0;
  logic       len_req_ready;
  logic [9:0] paddle_x;
  logic [9:0] paddle_y;
  logic [7:0] length;
  logic       at_left;
  logic       at_right;

  paddle_control #(
    .SCREEN_W(640),
    .PADDLE_Y(440),
    .LEN_MIN (32),
    .LEN_DEF (64),
    .LEN_MAX (128)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .frame_tick   (frame_tick),
    .rotary_event (rotary_event),
    .rotary_right (rotary_right),
    .speed        (speed),
    .len_req_valid(len_req_valid),
    .len_req      (len_req),
    .len_req_ready(len_req_ready),
    .paddle_x     (paddle_x),
    .paddle_y     (paddle_y),
    .length       (length),
    .at_left      (at_left),
    .at_right     (at_right)
  );

  always #10 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Model: resize is in progress exactly while the target differs from length.
  int m_x, m_len, m_t, m_pend;
  bit m_al, m_ar;

  typedef struct {
    bit en, tick, rot, right;
    int spd;
    bit valid;
    int req;
    int x, len;
    bit rdy, al, ar;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 288; m_len = 64; m_t = 64; m_pend = 0; m_al = 0; m_ar = 0;
  endtask

  task automatic model_step();
    int st, d, pe, nl, adj, raw, mx, r;
    bit rdy;
    rdy = (m_t == m_len);
    st  = (speed == 0) ? 1 : int'(speed);
    d   = (rotary_event && enable) ? (rotary_right ? st : -st) : 0;
    pe  = enable ? m_pend : 0;
    if (frame_tick) begin
      nl = m_len; adj = 0;
      if (m_t > m_len) begin nl = m_len + 2; adj = -1; end
      else if (m_t < m_len) begin nl = m_len - 2; adj = 1; end
      raw = m_x + pe + adj;
      mx  = 640 - nl;
      if (raw < 0) raw = 0;
      if (raw > mx) raw = mx;
      m_x = raw; m_len = nl;
      m_al = (raw == 0);
      m_ar = (raw + nl == 640);
      m_pend = d;
    end else if (enable) begin
      m_pend = m_pend + d;
      if (m_pend > 511) m_pend = 511;
      if (m_pend < -511) m_pend = -511;
    end else begin
      m_pend = 0;
    end
    if (rdy && len_req_valid) begin
      r = int'(len_req);
      if (r < 32) r = 32;
      if (r > 128) r = 128;
      m_t = r - (r % 2);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " paddle_x"}, int'(paddle_x), m_x);
    chk({tag, " paddle_y"}, int'(paddle_y), 440);
    chk({tag, " length"}, int'(length), m_len);
    chk({tag, " ready"}, int'(len_req_ready), int'(m_t == m_len));
    chk({tag, " at_left"}, int'(at_left), int'(m_al));
    chk({tag, " at_right"}, int'(at_right), int'(m_ar));
  endtask

  task automatic cyc(input bit en, input bit tick, input bit rot, input bit right,
                     input int spd, input bit valid, input int req);
    enable = en; frame_tick = tick; rotary_event = rot; rotary_right = right;
    speed = 4'(spd); len_req_valid = valid; len_req = 8'(req);
    @(posedge clock);
    model_step();
    @(negedge clock);
    frame_tick = 1'b0; rotary_event = 1'b0; len_req_valid = 1'b0;
  endtask

  task automatic tick();
    cyc(1, 1, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    #1;
    model_reset();
    chk("reset paddle_x", int'(paddle_x), 288);
    chk("reset length", int'(length), 64);
    chk_model("reset");
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 1, 1, 4,  0, 0,   288, 64, 1, 0, 0};
    tbl[1]  = '{1, 0, 1, 1, 4,  0, 0,   288, 64, 1, 0, 0};
    tbl[2]  = '{1, 0, 1, 1, 4,  0, 0,   288, 64, 1, 0, 0};
    tbl[3]  = '{1, 1, 0, 0, 0,  0, 0,   300, 64, 1, 0, 0};
    tbl[4]  = '{1, 0, 0, 0, 0,  1, 96,  300, 64, 0, 0, 0};
    tbl[5]  = '{1, 1, 0, 0, 0,  0, 0,   299, 66, 0, 0, 0};
    tbl[6]  = '{1, 0, 1, 0, 0,  0, 0,   299, 66, 0, 0, 0};
    tbl[7]  = '{1, 1, 1, 1, 2,  0, 0,   297, 68, 0, 0, 0};
    tbl[8]  = '{1, 1, 0, 0, 0,  0, 0,   298, 70, 0, 0, 0};
    tbl[9]  = '{1, 0, 0, 0, 0,  1, 200, 298, 70, 0, 0, 0};
    tbl[10] = '{0, 0, 1, 1, 15, 0, 0,   298, 70, 0, 0, 0};
    tbl[11] = '{0, 1, 0, 0, 0,  0, 0,   297, 72, 0, 0, 0};

    model_reset();
    #5;
    chk("async reset len_req_ready", int'(len_req_ready), 1);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].en, tbl[i].tick, tbl[i].rot, tbl[i].right, tbl[i].spd, tbl[i].valid, tbl[i].req);
      chk($sformatf("vec%0d paddle_x", i), int'(paddle_x), tbl[i].x);
      chk($sformatf("vec%0d length", i), int'(length), tbl[i].len);
      chk($sformatf("vec%0d ready", i), int'(len_req_ready), int'(tbl[i].rdy));
      chk($sformatf("vec%0d at_left", i), int'(at_left), int'(tbl[i].al));
      chk($sformatf("vec%0d at_right", i), int'(at_right), int'(tbl[i].ar));
    end
    for (int i = 0; i < 12; i++) cyc(0, 1, 1, 0, 9, 0, 0);
    chk("disabled resize x", int'(paddle_x), 285);
    chk("disabled resize len", int'(length), 96);
    chk("disabled resize ready", int'(len_req_ready), 1);

    // Left saturation and wall pinning.
    do_reset();
    for (int i = 0; i < 100; i++) cyc(1, 0, 1, 0, 15, 0, 0);
    chk("sat hold x", int'(paddle_x), 288);
    tick();
    chk("sat x", int'(paddle_x), 0);
    chk("sat at_left", int'(at_left), 1);
    cyc(1, 0, 1, 0, 3, 0, 0);
    tick();
    chk("wall x", int'(paddle_x), 0);
    chk("wall at_left", int'(at_left), 1);
    chk_model("wall");

    // Grow 64 -> 96 from the centre.
    do_reset();
    cyc(1, 0, 0, 0, 0, 1, 96);
    chk("grow ready", int'(len_req_ready), 0);
    tick();
    chk("grow1 len", int'(length), 66);
    chk("grow1 x", int'(paddle_x), 287);
    for (int i = 0; i < 15; i++) tick();
    chk("grow16 len", int'(length), 96);
    chk("grow16 x", int'(paddle_x), 272);
    chk("grow16 ready", int'(len_req_ready), 1);

    // Grow against the right wall.
    do_reset();
    for (int i = 0; i < 19; i++) cyc(1, 0, 1, 1, 15, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 1, 0, 0);
    tick();
    chk("right x", int'(paddle_x), 576);
    chk("right at_right", int'(at_right), 1);
    cyc(1, 0, 0, 0, 0, 1, 128);
    tick();
    chk("rgrow1 len", int'(length), 66);
    chk("rgrow1 x", int'(paddle_x), 574);
    for (int i = 0; i < 31; i++) tick();
    chk("rgrow32 len", int'(length), 128);
    chk("rgrow32 x", int'(paddle_x), 512);
    chk("rgrow32 at_right", int'(at_right), 1);
    chk_model("rgrow");

    // Undersized request clamps to the minimum.
    do_reset();
    cyc(1, 0, 0, 0, 0, 1, 10);
    for (int i = 0; i < 15; i++) tick();
    chk("shrink15 len", int'(length), 34);
    chk("shrink15 ready", int'(len_req_ready), 0);
    tick();
    chk("shrink16 len", int'(length), 32);
    chk("shrink16 x", int'(paddle_x), 304);
    chk("shrink16 ready", int'(len_req_ready), 1);

    // Event on the tick seeds the next frame.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 1, 2, 0, 0);
    cyc(1, 1, 1, 1, 2, 0, 0);
    chk("coinc x", int'(paddle_x), 294);
    tick();
    chk("coinc next x", int'(paddle_x), 296);

    // Request and tick together: only motion commits on that tick.
    do_reset();
    cyc(1, 0, 1, 1, 5, 0, 0);
    cyc(1, 1, 0, 0, 0, 1, 100);
    chk("reqtick x", int'(paddle_x), 293);
    chk("reqtick len", int'(length), 64);
    chk("reqtick ready", int'(len_req_ready), 0);
    tick();
    chk("reqtick next len", int'(length), 66);

    // Reset in the middle of a resize.
    do_reset();
    cyc(1, 0, 0, 0, 0, 1, 128);
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b0;
    #1;
    model_reset();
    chk("midreset len", int'(length), 64);
    chk("midreset x", int'(paddle_x), 288);
    chk("midreset ready", int'(len_req_ready), 1);
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("postreset len", int'(length), 64);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
          1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), $urandom_range(0, 9) == 0,
          int'($urandom_range(0, 255)));
      chk_model($sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
